// File: rtl/mmio_pwm_timer_if.sv
// Memory-mapped bus between an RV32I-style core and the PWM/timer block.
// Byte-addressed write and read ports. funct3 is shared by both and uses the
// RV32I load/store encoding.
interface mmio_pwm_timer_if;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;

  modport master (
    output write_mem, funct3, write_address, write_data, read_address,
    input  read_data
  );

  modport slave (
    input  write_mem, funct3, write_address, write_data, read_address,
    output read_data
  );
endinterface

// File: rtl/mmio_pwm_timer.sv
// Memory-mapped PWM generator with free-running MICROS/MILLIS timers and a
// millisecond compare interrupt.
//
// Duty writes go to shadow words. Each channel's active duty reloads from its
// shadow word at the period boundary, or continuously while PWM is disabled.
// This keeps the current period glitch-free.
module mmio_pwm_timer #(
  parameter int          NUM_CH    = 4,
  parameter int          PWM_BITS  = 8,
  parameter int          CLK_HZ    = 12000000,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFF00
) (
  input  logic              clk,
  input  logic              rst_n,
  mmio_pwm_timer_if.slave   bus,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  localparam int US_DIV = CLK_HZ / 1000000;
  localparam int MS_DIV = CLK_HZ / 1000;
  // Implemented CTRL bits are pwm_en, irq_en and one invert bit per channel
  // starting at bit 16. With NUM_CH=16 the shift wraps, which still gives the
  // right mask.
  localparam logic [31:0] CTRL_MASK =
    ((32'h1 << (16 + NUM_CH)) - 32'h0001_0000) | 32'h0000_0003;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  localparam logic [5:0] IDX_CTRL   = 6'd0;
  localparam logic [5:0] IDX_PRESC  = 6'd1;
  localparam logic [5:0] IDX_MILLIS = 6'd2;
  localparam logic [5:0] IDX_MICROS = 6'd3;
  localparam logic [5:0] IDX_CMP    = 6'd4;
  localparam logic [5:0] IDX_STATUS = 6'd5;
  localparam logic [5:0] IDX_DUTY0  = 6'd8;

  logic [31:0] ctrl_q, presc_q, cmp_q, millis, micros, us_div, ms_div;
  logic [31:0] duty_sh [NUM_CH];
  logic [PWM_BITS-1:0] duty_act [NUM_CH];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [15:0] psc_cnt;
  logic        pending;

  logic        wr_hit, rd_hit;
  logic [5:0]  widx, ridx;
  logic [3:0]  be;
  logic [31:0] lane_mask, wdata_al, rd_word, read_data_q;
  logic        pwm_en, irq_en, tick, wrap, us_tick, ms_tick, st_set, st_clr;
  logic [NUM_CH-1:0] invert, raw;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] mask,
                                        input logic [31:0] data);
    return (old & ~mask) | (data & mask);
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  a,
                                          input logic [2:0]  f);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? w[31:16] : w[15:0];
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    if (f[1])      return w;
    else if (f[0]) return f[2] ? {16'h0, h} : {{16{h[15]}}, h};
    else           return f[2] ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  assign wr_hit = bus.write_mem && (bus.write_address[31:8] == BASE_ADDR[31:8]);
  assign widx   = bus.write_address[7:2];
  assign rd_hit = (bus.read_address[31:8] == BASE_ADDR[31:8]);
  assign ridx   = bus.read_address[7:2];

  assign pwm_en = ctrl_q[0];
  assign irq_en = ctrl_q[1];
  assign invert = ctrl_q[16 +: NUM_CH];

  // Byte-lane enables and lane-replicated write data for sb/sh/sw
  always_comb begin
    be       = 4'b1111;
    wdata_al = bus.write_data;
    case (bus.funct3[1:0])
      2'b00: begin
        be       = 4'b0001 << bus.write_address[1:0];
        wdata_al = {4{bus.write_data[7:0]}};
      end
      2'b01: begin
        be       = bus.write_address[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{bus.write_data[15:0]}};
      end
      default: ;
    endcase
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  // Writable configuration registers and duty shadows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      cmp_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= '0;
    end else if (wr_hit) begin
      case (widx)
        IDX_CTRL:  ctrl_q  <= merge(ctrl_q, lane_mask, wdata_al) & CTRL_MASK;
        IDX_PRESC: presc_q <= merge(presc_q, lane_mask, wdata_al) & 32'h0000_FFFF;
        IDX_CMP:   cmp_q   <= merge(cmp_q, lane_mask, wdata_al);
        default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++)
        if (widx == IDX_DUTY0 + 6'(i))
          duty_sh[i] <= merge(duty_sh[i], lane_mask, wdata_al);
    end
  end

  assign us_tick = (us_div == 32'(US_DIV - 1));
  assign ms_tick = (ms_div == 32'(MS_DIV - 1));

  // Free-running microsecond and millisecond timers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_div <= '0;
      ms_div <= '0;
      micros <= '0;
      millis <= '0;
    end else begin
      if (us_tick) begin
        us_div <= '0;
        micros <= micros + 32'd1;
      end else begin
        us_div <= us_div + 32'd1;
      end
      if (ms_tick) begin
        ms_div <= '0;
        millis <= millis + 32'd1;
      end else begin
        ms_div <= ms_div + 32'd1;
      end
    end
  end

  assign st_set = ms_tick && ((millis + 32'd1) == cmp_q);
  assign st_clr = wr_hit && (widx == IDX_STATUS) && be[0] && wdata_al[0];

  // Sticky compare flag (a set wins over a same-cycle clear) and the registered irq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      irq     <= 1'b0;
    end else begin
      pending <= st_set | (pending & ~st_clr);
      irq     <= pending & irq_en;
    end
  end

  assign tick = pwm_en && (psc_cnt >= presc_q[15:0]);
  assign wrap = tick && (pwm_cnt == CNT_MAX);

  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) raw[i] = pwm_en && (pwm_cnt < duty_act[i]);
  end

  // Prescaler, PWM counter, active-duty reload and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt <= '0;
      pwm_cnt <= '0;
      pwm_out <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
    end else begin
      if (!pwm_en) begin
        psc_cnt <= '0;
        pwm_cnt <= '0;
      end else if (tick) begin
        psc_cnt <= '0;
        pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
        psc_cnt <= psc_cnt + 16'd1;
      end
      for (int i = 0; i < NUM_CH; i++)
        if (!pwm_en || wrap) duty_act[i] <= duty_sh[i][PWM_BITS-1:0];
      pwm_out <= raw ^ invert;
    end
  end

  // Read word selection; unmapped and out-of-window addresses read as zero
  always_comb begin
    rd_word = '0;
    if (rd_hit) begin
      case (ridx)
        IDX_CTRL:   rd_word = ctrl_q;
        IDX_PRESC:  rd_word = presc_q;
        IDX_MILLIS: rd_word = millis;
        IDX_MICROS: rd_word = micros;
        IDX_CMP:    rd_word = cmp_q;
        IDX_STATUS: rd_word = {31'h0, pending};
        default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++)
        if (ridx == IDX_DUTY0 + 6'(i)) rd_word = duty_sh[i];
    end
  end

  // Size and sign extraction happens before the register, giving one-cycle read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) read_data_q <= '0;
    else        read_data_q <= extract(rd_word, bus.read_address[1:0], bus.funct3);
  end

  assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_mmio_pwm_timer.sv
// Directed bench for mmio_pwm_timer with default parameters
// (4 channels, 8-bit PWM, 12 MHz clock).
module tb_mmio_pwm_timer;
  localparam logic [31:0] BASE = 32'hFFFFFF00;
  localparam logic [2:0] F_LB = 3'b000, F_LH = 3'b001, F_LW = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100, F_LHU = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pwm_out;
  logic       irq;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  mmio_pwm_timer_if bus();

  mmio_pwm_timer dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pwm_out(pwm_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Counts rising edges since reset release; read on negedges only.
  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    bus.write_mem     = 1'b1;
    bus.write_address = addr;
    bus.write_data    = data;
    bus.funct3        = f3;
    @(negedge clk);
    bus.write_mem     = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] exp);
    bus.write_mem    = 1'b0;
    bus.read_address = addr;
    bus.funct3       = f3;
    @(negedge clk);
    chk(tag, bus.read_data, exp);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      hi += int'(pwm_out[ch]);
    end
  endtask

  initial begin
    int hi, hi2, c;
    logic prev, found;
    bus.write_mem = 1'b0;
    bus.funct3 = F_LW;
    bus.write_address = '0;
    bus.write_data = '0;
    bus.read_address = '0;

    repeat (3) @(negedge clk);
    chk("rst_read_data", bus.read_data, 32'h0);
    chk("rst_pwm_out", 32'(pwm_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // MICROS right after reset and 1000 cycles later; MILLIS still 0.
    bus.read_address = BASE + 32'h0C;
    rst_n = 1'b1;
    @(negedge clk);
    chk("micros_start", bus.read_data, 32'd0);
    repeat (1000) @(negedge clk);
    chk("micros_1000", bus.read_data, 32'd83);
    rd_chk("millis_start", BASE + 32'h08, F_LW, 32'd0);

    // MILLIS and MICROS ignore writes.
    bus_wr(BASE + 32'h08, 32'hDEADBEEF, F_LW);
    bus_wr(BASE + 32'h0C, 32'hDEADBEEF, F_LW);
    rd_chk("millis_ro", BASE + 32'h08, F_LW, 32'd0);
    c = cyc;
    rd_chk("micros_ro", BASE + 32'h0C, F_LW, 32'(c / 12));

    bus_wr(BASE + 32'h04, 32'hABCD0005, F_LW);
    rd_chk("presc_mask", BASE + 32'h04, F_LW, 32'h0000_0005);
    bus_wr(BASE + 32'h04, 32'h0, F_LW);

    // Duties load immediately while PWM is disabled.
    bus_wr(BASE + 32'h20, 32'd64, F_LW);
    bus_wr(BASE + 32'h24, 32'd50, F_LW);
    bus_wr(BASE + 32'h00, 32'h1, F_LW);
    repeat (300) @(negedge clk);
    count_high(0, 256, hi);
    chk("duty64_high", 32'(hi), 32'd64);
    count_high(3, 256, hi);
    chk("duty0_ch3_high", 32'(hi), 32'd0);

    // Duty change mid-period takes effect at the next period.
    found = 1'b0;
    prev = pwm_out[1];
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (pwm_out[1] && !prev) found = 1'b1;
      prev = pwm_out[1];
    end
    chk("ch1_rise_seen", 32'(found), 32'd1);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      hi += int'(pwm_out[1]);
      if (i == 10) begin
        bus.write_mem = 1'b1;
        bus.write_address = BASE + 32'h24;
        bus.write_data = 32'd200;
        bus.funct3 = F_LW;
      end
      if (i == 11) bus.write_mem = 1'b0;
      @(negedge clk);
    end
    hi2 = 0;
    for (int i = 0; i < 256; i++) begin
      hi2 += int'(pwm_out[1]);
      @(negedge clk);
    end
    chk("ch1_cur_period", 32'(hi), 32'd50);
    chk("ch1_next_period", 32'(hi2), 32'd200);

    bus_wr(BASE + 32'h20, 32'd0, F_LW);
    repeat (300) @(negedge clk);
    count_high(0, 256, hi);
    chk("duty0_const_low", 32'(hi), 32'd0);

    // Byte and halfword lanes and load extraction.
    bus_wr(BASE + 32'h21, 32'h556677AB, F_LB);
    rd_chk("sb_lw", BASE + 32'h20, F_LW, 32'h0000AB00);
    rd_chk("sb_lb", BASE + 32'h21, F_LB, 32'hFFFFFFAB);
    rd_chk("sb_lbu", BASE + 32'h21, F_LBU, 32'h000000AB);
    rd_chk("lh_low", BASE + 32'h20, F_LH, 32'hFFFFAB00);
    bus_wr(BASE + 32'h22, 32'h99991234, F_LH);
    rd_chk("sh_lw", BASE + 32'h20, F_LW, 32'h1234AB00);
    rd_chk("sh_lhu", BASE + 32'h22, F_LHU, 32'h00001234);

    // A write and a read of the same register in one cycle return the old value.
    bus.write_mem = 1'b1;
    bus.write_address = BASE + 32'h10;
    bus.write_data = 32'h11;
    bus.read_address = BASE + 32'h10;
    bus.funct3 = F_LW;
    @(negedge clk);
    bus.write_mem = 1'b0;
    chk("rw_same_old", bus.read_data, 32'h0);
    rd_chk("rw_same_new", BASE + 32'h10, F_LW, 32'h11);

    // Prescaler of 1 doubles the period: 200 of 256 counts becomes 400 of 512 cycles.
    bus_wr(BASE + 32'h04, 32'h1, F_LW);
    repeat (600) @(negedge clk);
    count_high(1, 512, hi);
    chk("presc1_ch1_high", 32'(hi), 32'd400);

    // Invert channel 2 with duty 0 gives a constant-high output.
    bus_wr(BASE + 32'h00, 32'hFFF4FFF1, F_LW);
    rd_chk("ctrl_mask", BASE + 32'h00, F_LW, 32'h00040001);
    count_high(2, 300, hi);
    chk("inv2_const_high", 32'(hi), 32'd300);
    rd_chk("unmapped_40", BASE + 32'h40, F_LW, 32'h0);
    rd_chk("unmapped_18", BASE + 32'h18, F_LW, 32'h0);
    rd_chk("duty4_absent", BASE + 32'h30, F_LW, 32'h0);
    rd_chk("out_of_window", 32'h0000_0000, F_LW, 32'h0);

    // Millisecond compare: MILLIS reaches 3 at cycle 36000.
    bus_wr(BASE + 32'h10, 32'd3, F_LW);
    bus_wr(BASE + 32'h00, 32'h00040003, F_LW);
    rd_chk("status_idle", BASE + 32'h14, F_LW, 32'h0);
    chk("irq_idle", 32'(irq), 32'h0);
    while (cyc < 35999) @(negedge clk);
    bus.read_address = BASE + 32'h08;
    bus.funct3 = F_LW;
    @(negedge clk);
    chk("millis_2", bus.read_data, 32'd2);
    chk("irq_before", 32'(irq), 32'h0);
    @(negedge clk);
    chk("millis_3", bus.read_data, 32'd3);
    chk("irq_rise", 32'(irq), 32'h1);
    rd_chk("status_set", BASE + 32'h14, F_LW, 32'h1);
    bus_wr(BASE + 32'h14, 32'h1, F_LW);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'h0);
    rd_chk("status_cleared", BASE + 32'h14, F_LW, 32'h0);

    // A W1C write landing on the same edge as a new match leaves pending set.
    bus_wr(BASE + 32'h10, 32'd4, F_LW);
    while (cyc < 47999) @(negedge clk);
    bus_wr(BASE + 32'h14, 32'h1, F_LW);
    rd_chk("set_wins_status", BASE + 32'h14, F_LW, 32'h1);
    chk("set_wins_irq", 32'(irq), 32'h1);
    rd_chk("millis_4", BASE + 32'h08, F_LW, 32'd4);

    // Asynchronous reset clears outputs without waiting for a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", 32'(pwm_out), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    chk("async_rst_rdata", bus.read_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
